clken_rst_seq: RTL and testbench
================================

Name: clken_rst_seq

Overview:
- Synthesizable, parametrised successor to the testbench clock/reset source.
- Derives NCH divided clock-enable channels from the single pixel clock pck.
- Releases NCH active-low channel resets in a staggered sequence after cken is held high for a programmable delay.
- Sits at the top of the frame-converter core and feeds the line/frame timing blocks and the per-domain reset nets.

Parameters:
- NCH, 3, number of enable/reset channels (1..8)
- DIV_W, 8, width of each channel divide ratio
- RST_DLY, 16, pck edges with cken high before channel 0 releases
- STAGGER, 4, extra pck edges between successive channel releases
- DIV_DEF, 1, divide ratio loaded into every channel on reset

Ports:
- pck, in, 1, pixel clock; all logic on its rising edge
- rst, in, 1, synchronous active-high reset
- cken, in, 1, clock-valid qualifier; low holds all channels in reset
- div_val, in, NCH*DIV_W, requested ratios; channel i uses bits [i*DIV_W +: DIV_W]
- div_load, in, NCH, per-channel strobe capturing div_val slice into pending register
- ce_out, out, NCH, one-pck-wide enable pulse per channel
- ph_out, out, NCH, 50%-style phase flag; toggles on every ce_out pulse
- rstb_out, out, NCH, active-low channel reset; 1 = released
- all_ready, out, 1, high when every rstb_out bit is 1

Behaviour:
- Synchronous, active-high reset (rst sampled on pck rising edge). Outputs after reset:
  - ce_out=0, ph_out=0, rstb_out=0, all_ready=0
  - Sequence counter = 0
  - Active and pending ratios = DIV_DEF
- Release thresholds:
  - T_i = RST_DLY + i*STAGGER
  - Counter width = clog2(T_(NCH-1)+1)
- Sequencer, on each edge:
  - If cken=0: counter goes to 0 and all rstb_out go to 0 on that edge.
  - Else the counter increments, saturating at T_(NCH-1).
  - rstb_out[i] is registered high on the T_i-th consecutive edge with cken=1.
  - With defaults, release edges are 16, 20, 24.
- all_ready: registered AND of rstb_out, one edge behind the last release.
- cken dropping mid-sequence or after full release: all channels return to reset on the next edge, and the sequence restarts from 0 when cken returns.
- Per-channel divider while rstb_out[i]=0:
  - dcnt=0, ce_out[i]=0, ph_out[i]=0
  - active ratio <= pending ratio (a load during reset takes effect immediately)
- Per-channel divider while released, with N = active ratio (0 treated as 1):
  - If dcnt==N-1: dcnt<=0, ce_out[i]<=1, ph_out[i] toggles.
  - Else: dcnt<=dcnt+1, ce_out[i]<=0.
  - N=1 gives ce_out[i] continuously high and ph_out toggling every edge.
  - First pulse: ce_out[i] is high on the N-th edge after the edge that set rstb_out[i].
- Ratio change:
  - A div_load[i] strobe captures the ratio into pending.
  - Active updates only on the terminal edge (dcnt==N-1), so there are no runt periods.
  - Simultaneous load and terminal edge: the old pending value is applied; the new value waits for the next terminal edge.
  - Multiple loads before a terminal edge: the last one wins.
- rst overrides cken, div_load and everything else.

Optional Feature:
- Macro CKGEN_ALIGN_EN.
- When defined:
  - Adds input port align (1 bit).
  - align=1 on an edge forces dcnt=0 and ph_out=0, and suppresses ce_out on all released channels on that edge. Counting restarts on the next edge, so all channels are phase-aligned.
  - align is ignored for channels still in reset.
  - align and a terminal edge together: align wins, no pulse is generated, and the pending ratio is still applied.
- When undefined: no align port; dividers free-run.

Test Plan:
1. Reset release: rst=1 for 3 edges, then rst=0 with cken=1 held → rstb_out releases at edges 16/20/24 after the first cken-high edge; all_ready rises at edge 25.
2. cken dropout: cken=0 for 1 edge at edge 18 → rstb_out=000 on the next edge; after cken=1 again, releases at 16/20/24 relative to the restart.
3. Divide ratios: div_val={3,2,0} loaded during reset → ch0 ce every 3 edges, ch1 every 2, ch2 ce continuously high; ph_out periods 6/4/2 edges.
4. Glitch-free change: ch0 running N=5, div_load with 2 at dcnt=1 → remaining pulses 5 edges apart until the next terminal edge, then 2 edges apart; no pulse gap <2.
5. Zero/max ratio: div_val=255 → exactly one ce per 255 edges; div_val=0 behaves as 1.
6. (CKGEN_ALIGN_EN) ch0 N=4, ch1 N=3 free-running, align pulse → both ce_out fire together 4 and 3 edges after align, and ph_out=0 right after align.

Source files
------------

// File: rtl/clken_rst_seq.sv
// -----------------------------------------------------------------------------
// clken_rst_seq
//
// Clock-enable and reset sequencer at the top of the frame-converter core.
// From the single pixel clock pck it derives NCH divided clock-enable channels
// and releases NCH active-low channel resets in a staggered sequence once cken
// has been held high for RST_DLY edges.
//
// Ports
//   pck        in   1          pixel clock, everything runs on its rising edge
//   rst        in   1          synchronous active-high reset, overrides all
//   cken       in   1          clock-valid qualifier; low holds channels in reset
//   div_val    in   NCH*DIV_W  requested ratios, channel i at [i*DIV_W +: DIV_W]
//   div_load   in   NCH        per-channel strobe capturing div_val into pending
//   align      in   1          (CKGEN_ALIGN_EN only) phase-align released dividers
//   ce_out     out  NCH        one-pck-wide enable pulse per channel
//   ph_out     out  NCH        phase flag, toggles on every ce_out pulse
//   rstb_out   out  NCH        active-low channel reset, 1 = released
//   all_ready  out  1          registered AND of rstb_out
//
// Configuration
//   CKGEN_ALIGN_EN  when defined, adds the align input. Without it the
//                   dividers free-run.
// -----------------------------------------------------------------------------
module clken_rst_seq #(
  parameter int NCH     = 3,
  parameter int DIV_W   = 8,
  parameter int RST_DLY = 16,
  parameter int STAGGER = 4,
  parameter int DIV_DEF = 1
) (
  input  logic                 pck,
  input  logic                 rst,
  input  logic                 cken,
  input  logic [NCH*DIV_W-1:0] div_val,
  input  logic [NCH-1:0]       div_load,
`ifdef CKGEN_ALIGN_EN
  input  logic                 align,
`endif
  output logic [NCH-1:0]       ce_out,
  output logic [NCH-1:0]       ph_out,
  output logic [NCH-1:0]       rstb_out,
  output logic                 all_ready
);

  // Last channel's release threshold; the sequence counter saturates here.
  localparam int T_LAST = RST_DLY + (NCH - 1) * STAGGER;
  localparam int CNT_W  = (T_LAST < 1) ? 1 : $clog2(T_LAST + 1);

  localparam logic [CNT_W-1:0] SEQ_MAX   = CNT_W'(T_LAST);
  localparam logic [DIV_W-1:0] RATIO_DEF = DIV_W'(DIV_DEF);

  // Release threshold of channel i, in consecutive cken-high edges.
  function automatic logic [CNT_W-1:0] thresh(input int i);
    return CNT_W'(RST_DLY + i * STAGGER);
  endfunction

  // Saturating increment of the sequence counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SEQ_MAX) ? v : v + CNT_W'(1);
  endfunction

  // A programmed ratio of zero behaves as divide-by-one.
  function automatic logic [DIV_W-1:0] eff_ratio(input logic [DIV_W-1:0] r);
    return (r == '0) ? DIV_W'(1) : r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [NCH-1:0]   rstb_q, rstb_d;
  logic             rdy_q, rdy_d;

  logic [DIV_W-1:0] dcnt_q [NCH];
  logic [DIV_W-1:0] dcnt_d [NCH];
  logic [DIV_W-1:0] act_q  [NCH];
  logic [DIV_W-1:0] act_d  [NCH];
  logic [DIV_W-1:0] pend_q [NCH];
  logic [DIV_W-1:0] pend_d [NCH];
  logic [NCH-1:0]   ce_q, ce_d;
  logic [NCH-1:0]   ph_q, ph_d;
  logic [NCH-1:0]   term;
  logic             align_s;

`ifdef CKGEN_ALIGN_EN
  assign align_s = align;
`else
  assign align_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Release sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    seq_d  = seq_q;
    rstb_d = rstb_q;
    if (!cken) begin
      // Losing the clock qualifier drops every channel back into reset and
      // restarts the release sequence from scratch.
      seq_d  = '0;
      rstb_d = '0;
    end else begin
      seq_d = sat_inc(seq_q);
      // seq_d equals the number of consecutive cken-high edges including this
      // one, so a channel releases on exactly its T_i-th edge.
      for (int i = 0; i < NCH; i++) begin
        rstb_d[i] = (seq_d >= thresh(i));
      end
    end
  end

  // One edge behind rstb_out by construction.
  assign rdy_d = &rstb_q;

  // ---------------------------------------------------------------------------
  // Per-channel dividers
  // ---------------------------------------------------------------------------
  always_comb begin
    ce_d = '0;
    ph_d = ph_q;
    term = '0;
    for (int i = 0; i < NCH; i++) begin
      pend_d[i] = div_load[i] ? div_val[i*DIV_W +: DIV_W] : pend_q[i];
      act_d[i]  = act_q[i];
      dcnt_d[i] = dcnt_q[i];
      term[i]   = (dcnt_q[i] == eff_ratio(act_q[i]) - DIV_W'(1));

      if (!rstb_q[i]) begin
        // Held in reset: a ratio loaded now is live from the first period.
        dcnt_d[i] = '0;
        ph_d[i]   = 1'b0;
        act_d[i]  = pend_d[i];
      end else if (align_s) begin
        // Alignment restarts every released channel from count 0 with no
        // pulse. A terminal edge coinciding with it still commits the pending
        // ratio so that a queued ratio change is not lost.
        dcnt_d[i] = '0;
        ph_d[i]   = 1'b0;
        if (term[i]) begin
          act_d[i] = pend_q[i];
        end
      end else if (term[i]) begin
        // Ratio changes are committed only here, so a period is never cut
        // short. pend_q (not pend_d) is used: a load on this very edge waits
        // for the next terminal edge.
        dcnt_d[i] = '0;
        ce_d[i]   = 1'b1;
        ph_d[i]   = ~ph_q[i];
        act_d[i]  = pend_q[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + DIV_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pck) begin
    if (rst) begin
      seq_q  <= '0;
      rstb_q <= '0;
      rdy_q  <= 1'b0;
      ce_q   <= '0;
      ph_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        dcnt_q[i] <= '0;
        act_q[i]  <= RATIO_DEF;
        pend_q[i] <= RATIO_DEF;
      end
    end else begin
      seq_q  <= seq_d;
      rstb_q <= rstb_d;
      rdy_q  <= rdy_d;
      ce_q   <= ce_d;
      ph_q   <= ph_d;
      for (int i = 0; i < NCH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        act_q[i]  <= act_d[i];
        pend_q[i] <= pend_d[i];
      end
    end
  end

  assign ce_out    = ce_q;
  assign ph_out    = ph_q;
  assign rstb_out  = rstb_q;
  assign all_ready = rdy_q;

endmodule

// File: tb/tb_clken_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_clken_rst_seq
//
// Directed testbench for clken_rst_seq with default parameters (NCH=3,
// DIV_W=8, RST_DLY=16, STAGGER=4, DIV_DEF=1). Outputs are sampled 1 time unit
// after each rising edge; "edge e" below is the e-th edge after rst drops.
// The align test is built only when CKGEN_ALIGN_EN is defined.
// -----------------------------------------------------------------------------
module tb_clken_rst_seq;

  logic        pck = 1'b0;
  logic        rst;
  logic        cken;
  logic [23:0] div_val;
  logic [2:0]  div_load;
  logic [2:0]  ce_out;
  logic [2:0]  ph_out;
  logic [2:0]  rstb_out;
  logic        all_ready;
`ifdef CKGEN_ALIGN_EN
  logic        align;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clken_rst_seq dut (
    .pck       (pck),
    .rst       (rst),
    .cken      (cken),
    .div_val   (div_val),
    .div_load  (div_load),
`ifdef CKGEN_ALIGN_EN
    .align     (align),
`endif
    .ce_out    (ce_out),
    .ph_out    (ph_out),
    .rstb_out  (rstb_out),
    .all_ready (all_ready)
  );

  always #5 pck = ~pck;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pck);
    #1;
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    cken     = 1'b1;
    div_load = '0;
    div_val  = '0;
`ifdef CKGEN_ALIGN_EN
    align    = 1'b0;
`endif
    repeat (3) tick();
  endtask

  // Expected release vector j edges into an uninterrupted cken-high run.
  function automatic logic [2:0] exp_rstb(input int j);
    return {j >= 24, j >= 20, j >= 16};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel [3];
    int nr  [3];
    int cnt, first, second;
    logic [2:0] ce_e, ph_e;

    // ---- 1: reset state and staggered release -----------------------------
    do_reset();
    check_val("rst_rstb", 32'(rstb_out), 32'h0);
    check_val("rst_ce",   32'(ce_out),   32'h0);
    check_val("rst_ph",   32'(ph_out),   32'h0);
    check_val("rst_rdy",  32'(all_ready), 32'h0);
    rst = 1'b0;
    for (int e = 1; e <= 26; e++) begin
      tick();
      check_val($sformatf("rel_rstb_e%0d", e), 32'(rstb_out), 32'(exp_rstb(e)));
      check_val($sformatf("rel_rdy_e%0d", e), 32'(all_ready), 32'(e >= 25));
      if (e == 16) check_val("rel_ce0_e16", 32'(ce_out[0]), 32'h0);
      if (e == 17) check_val("rel_ce0_e17", 32'(ce_out[0]), 32'h1);
      if (e == 17) check_val("rel_ph0_e17", 32'(ph_out[0]), 32'h1);
      if (e == 18) check_val("rel_ph0_e18", 32'(ph_out[0]), 32'h0);
    end

    // ---- 2: cken dropout mid-sequence -------------------------------------
    do_reset();
    rst = 1'b0;
    repeat (17) tick();
    check_val("drop_pre_rstb", 32'(rstb_out), 32'h1);
    cken = 1'b0;
    tick();   // edge 18
    check_val("drop_rstb", 32'(rstb_out), 32'h0);
    check_val("drop_rdy",  32'(all_ready), 32'h0);
    cken = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      tick();
      check_val($sformatf("restart_rstb_j%0d", j), 32'(rstb_out), 32'(exp_rstb(j)));
      if (j == 1)  check_val("restart_ce_j1", 32'(ce_out), 32'h0);
      if (j == 24) check_val("restart_rdy_j24", 32'(all_ready), 32'h0);
      if (j == 25) check_val("restart_rdy_j25", 32'(all_ready), 32'h1);
    end

    // ---- 3: ratios 3/2/0 loaded during channel reset ----------------------
    do_reset();
    rst      = 1'b0;
    div_val  = {8'd0, 8'd2, 8'd3};
    div_load = 3'b111;
    rel = '{16, 20, 24};
    nr  = '{3, 2, 1};
    for (int e = 1; e <= 40; e++) begin
      tick();
      div_load = '0;
      ce_e = '0;
      ph_e = '0;
      for (int i = 0; i < 3; i++) begin
        if (e > rel[i]) begin
          ce_e[i] = ((e - rel[i]) % nr[i]) == 0;
          ph_e[i] = (((e - rel[i]) / nr[i]) % 2) == 1;
        end
      end
      if (e >= 14) begin
        check_val($sformatf("div_ce_e%0d", e), 32'(ce_out), 32'(ce_e));
        check_val($sformatf("div_ph_e%0d", e), 32'(ph_out), 32'(ph_e));
      end
    end

    // ---- 4: glitch-free ratio change on ch0 (5 -> 2 -> 4) -----------------
    // N=5 pulses at 21,26; load 2 at edge 23 (dcnt=1) commits at 26 -> 28,30,
    // 32; load 4 on terminal edge 32 waits: 34 still N=2, then 38,42.
    do_reset();
    rst      = 1'b0;
    div_val  = {8'd1, 8'd1, 8'd5};
    div_load = 3'b001;
    tick();
    div_load = '0;
    for (int e = 2; e <= 43; e++) begin
      if (e == 23) begin
        div_val[7:0] = 8'd2;
        div_load     = 3'b001;
      end else if (e == 32) begin
        div_val[7:0] = 8'd4;
        div_load     = 3'b001;
      end else begin
        div_load = '0;
      end
      tick();
      if (e >= 17)
        check_val($sformatf("chg_ce0_e%0d", e), 32'(ce_out[0]),
                  32'(e == 21 || e == 26 || e == 28 || e == 30 || e == 32 ||
                      e == 34 || e == 38 || e == 42));
    end
    div_load = '0;

    // ---- 5: max ratio 255 on ch0, zero ratio on ch1 -----------------------
    do_reset();
    rst      = 1'b0;
    div_val  = {8'd1, 8'd0, 8'd255};
    div_load = 3'b111;
    cnt = 0; first = 0; second = 0;
    for (int e = 1; e <= 530; e++) begin
      tick();
      div_load = '0;
      if (ce_out[0]) begin
        cnt++;
        if (cnt == 1) first = e;
        if (cnt == 2) second = e;
      end
      if (e == 21) check_val("zero_ce1_e21", 32'(ce_out[1]), 32'h1);
      if (e == 21) check_val("zero_ph1_e21", 32'(ph_out[1]), 32'h1);
      if (e == 22) check_val("zero_ce1_e22", 32'(ce_out[1]), 32'h1);
      if (e == 22) check_val("zero_ph1_e22", 32'(ph_out[1]), 32'h0);
    end
    check_val("max_count",  32'(cnt),    32'd2);
    check_val("max_first",  32'(first),  32'd271);
    check_val("max_second", 32'(second), 32'd526);

`ifdef CKGEN_ALIGN_EN
    // ---- 6: align pulse with ch0 N=4, ch1 N=3 -----------------------------
    do_reset();
    rst      = 1'b0;
    div_val  = {8'd1, 8'd3, 8'd4};
    div_load = 3'b111;
    tick();
    div_load = '0;
    repeat (39) tick();   // edge 40
    align = 1'b1;
    tick();               // edge 41
    align = 1'b0;
    check_val("align_ce", 32'(ce_out), 32'h0);
    check_val("align_ph", 32'(ph_out[1:0]), 32'h0);
    for (int e = 42; e <= 47; e++) begin
      tick();
      check_val($sformatf("align_ce0_e%0d", e), 32'(ce_out[0]), 32'(e == 45));
      check_val($sformatf("align_ce1_e%0d", e), 32'(ce_out[1]),
                32'(e == 44 || e == 47));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
